// File: rtl/rv2axi_pkg.sv
// Shared types and constants for the ready/valid-to-AXI4-Lite master bridge.
package rv2axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_WR_RESP  = 3'd2,
        S_RD_ADDR  = 3'd3,
        S_RD_DATA  = 3'd4,
        S_RSP      = 3'd5
    } rv2axi_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ready_valid_to_axi.sv
// AXI4-Lite master: one ready/valid command in, one AXI transaction out, response back.
// Optional RV2AXI_WSTRB_EN adds cmd_wstrb_i; otherwise M00_AXI_wstrb is all ones.
module ready_valid_to_axi
    import rv2axi_pkg::*;
#(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 32
) (
    input  logic                                M00_AXI_aclk,
    input  logic                                M00_AXI_aresetn,

    input  logic                                cmd_valid_i,
    output logic                                cmd_ready_o,
    input  logic                                cmd_write_i,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata_i,
`ifdef RV2AXI_WSTRB_EN
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb_i,
`endif

    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic                                rsp_write_o,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic [1:0]                          rsp_resp_o,
    output logic                                rsp_error_o,

    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     M00_AXI_awaddr,
    output logic [2:0]                          M00_AXI_awprot,
    output logic                                M00_AXI_awvalid,
    input  logic                                M00_AXI_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     M00_AXI_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   M00_AXI_wstrb,
    output logic                                M00_AXI_wvalid,
    input  logic                                M00_AXI_wready,
    input  logic [1:0]                          M00_AXI_bresp,
    input  logic                                M00_AXI_bvalid,
    output logic                                M00_AXI_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     M00_AXI_araddr,
    output logic [2:0]                          M00_AXI_arprot,
    output logic                                M00_AXI_arvalid,
    input  logic                                M00_AXI_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     M00_AXI_rdata,
    input  logic [1:0]                          M00_AXI_rresp,
    input  logic                                M00_AXI_rvalid,
    output logic                                M00_AXI_rready
);

    rv2axi_state_t                          state_q, state_d;
    logic                                   awvalid_q, awvalid_d;
    logic                                   wvalid_q, wvalid_d;
    logic                                   arvalid_q, arvalid_d;
    logic                                   bready_q, bready_d;
    logic                                   rready_q, rready_d;
    logic                                   rsp_valid_q, rsp_valid_d;
    logic                                   rsp_write_q, rsp_write_d;
    logic [C_M00_AXI_DATA_WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                             rsp_resp_q, rsp_resp_d;
    logic [C_M00_AXI_ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [C_M00_AXI_DATA_WIDTH-1:0]        wdata_q, wdata_d;
`ifdef RV2AXI_WSTRB_EN
    logic [C_M00_AXI_DATA_WIDTH/8-1:0]      wstrb_q, wstrb_d;
`endif

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef RV2AXI_WSTRB_EN
        wstrb_d     = wstrb_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
`ifdef RV2AXI_WSTRB_EN
                    wstrb_d = cmd_wstrb_i;
`endif
                    if (cmd_write_i) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; leave only once both are gone.
                if (awvalid_q && M00_AXI_awready) awvalid_d = 1'b0;
                if (wvalid_q && M00_AXI_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M00_AXI_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M00_AXI_bresp;
                    state_d     = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (M00_AXI_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M00_AXI_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = M00_AXI_rdata;
                    rsp_resp_d  = M00_AXI_rresp;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge M00_AXI_aclk or negedge M00_AXI_aresetn) begin
        if (!M00_AXI_aresetn) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef RV2AXI_WSTRB_EN
            wstrb_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef RV2AXI_WSTRB_EN
            wstrb_q     <= wstrb_d;
`endif
        end
    end

    // Gated by reset so no command is offered while the bridge is held in reset.
    assign cmd_ready_o     = (state_q == S_IDLE) && M00_AXI_aresetn;

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_write_o     = rsp_write_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_resp_o      = rsp_resp_q;
    assign rsp_error_o     = rsp_resp_q[1];

    assign M00_AXI_awaddr  = addr_q;
    assign M00_AXI_awprot  = 3'b000;
    assign M00_AXI_awvalid = awvalid_q;
    assign M00_AXI_wdata   = wdata_q;
`ifdef RV2AXI_WSTRB_EN
    assign M00_AXI_wstrb   = wstrb_q;
`else
    assign M00_AXI_wstrb   = '1;
`endif
    assign M00_AXI_wvalid  = wvalid_q;
    assign M00_AXI_bready  = bready_q;
    assign M00_AXI_araddr  = addr_q;
    assign M00_AXI_arprot  = 3'b000;
    assign M00_AXI_arvalid = arvalid_q;
    assign M00_AXI_rready  = rready_q;

endmodule

// File: tb/tb_ready_valid_to_axi.sv
// Directed bench for ready_valid_to_axi; the bench itself plays the AXI slave cycle by cycle.
module tb_ready_valid_to_axi;
    import rv2axi_pkg::*;

    logic        clk;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_err = 0;

    ready_valid_to_axi #(
        .C_M00_AXI_DATA_WIDTH (32),
        .C_M00_AXI_ADDR_WIDTH (32)
    ) dut (
        .M00_AXI_aclk    (clk),
        .M00_AXI_aresetn (aresetn),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_write_i     (cmd_write),
        .cmd_addr_i      (cmd_addr),
        .cmd_wdata_i     (cmd_wdata),
`ifdef RV2AXI_WSTRB_EN
        .cmd_wstrb_i     (cmd_wstrb),
`endif
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_write_o     (rsp_write),
        .rsp_rdata_o     (rsp_rdata),
        .rsp_resp_o      (rsp_resp),
        .rsp_error_o     (rsp_error),
        .M00_AXI_awaddr  (awaddr),
        .M00_AXI_awprot  (awprot),
        .M00_AXI_awvalid (awvalid),
        .M00_AXI_awready (awready),
        .M00_AXI_wdata   (wdata),
        .M00_AXI_wstrb   (wstrb),
        .M00_AXI_wvalid  (wvalid),
        .M00_AXI_wready  (wready),
        .M00_AXI_bresp   (bresp),
        .M00_AXI_bvalid  (bvalid),
        .M00_AXI_bready  (bready),
        .M00_AXI_araddr  (araddr),
        .M00_AXI_arprot  (arprot),
        .M00_AXI_arvalid (arvalid),
        .M00_AXI_arready (arready),
        .M00_AXI_rdata   (rdata),
        .M00_AXI_rresp   (rresp),
        .M00_AXI_rvalid  (rvalid),
        .M00_AXI_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just past the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        aresetn   = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        // Reset state
        #12;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        step();

        // 1: zero-wait write, OKAY
        send_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'b0101);
        check("wr1_c1_awvalid", {31'd0, awvalid}, 32'd1);
        check("wr1_c1_wvalid", {31'd0, wvalid}, 32'd1);
        check("wr1_c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("wr1_awaddr", awaddr, 32'h4);
        check("wr1_wdata", wdata, 32'hDEADBEEF);
        check("wr1_prot", {26'd0, awprot, arprot}, 32'd0);
`ifdef RV2AXI_WSTRB_EN
        check("wr1_wstrb", {28'd0, wstrb}, 32'h5);
`else
        check("wr1_wstrb", {28'd0, wstrb}, 32'hF);
`endif
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        check("wr1_c2_aw_w_low", {30'd0, awvalid, wvalid}, 32'd0);
        check("wr1_c2_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1; bresp = RESP_OKAY;
        step();
        bvalid = 1'b0;
        check("wr1_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr1_c3_bready", {31'd0, bready}, 32'd0);
        check("wr1_rsp_write", {31'd0, rsp_write}, 32'd1);
        check("wr1_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        check("wr1_rsp_error", {31'd0, rsp_error}, 32'd0);
        check("wr1_rsp_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wr1_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // 2: read with 5 AR wait cycles
        send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
        check("rd2_araddr", araddr, 32'h8);
        for (int i = 0; i < 5; i++) begin
            check("rd2_arvalid_held", {31'd0, arvalid}, 32'd1);
            step();
        end
        check("rd2_arvalid_still", {31'd0, arvalid}, 32'd1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("rd2_arvalid_drop", {31'd0, arvalid}, 32'd0);
        check("rd2_rready", {31'd0, rready}, 32'd1);
        rvalid = 1'b1; rdata = 32'h12345678; rresp = RESP_OKAY;
        step();
        rvalid = 1'b0;
        check("rd2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd2_rsp_rdata", rsp_rdata, 32'h12345678);
        check("rd2_rsp_write", {31'd0, rsp_write}, 32'd0);
        check("rd2_rsp_error", {31'd0, rsp_error}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 3: W accepted 3 cycles before AW
        send_cmd(1'b1, 32'h20, 32'hA5A5_0F0F, 4'b1111);
        wready = 1'b1;
        step();
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr3_wvalid_low", {31'd0, wvalid}, 32'd0);
            check("wr3_awvalid_held", {31'd0, awvalid}, 32'd1);
            check("wr3_no_bready", {31'd0, bready}, 32'd0);
            if (i == 2) awready = 1'b1;
            step();
        end
        awready = 1'b0;
        check("wr3_awvalid_drop", {31'd0, awvalid}, 32'd0);
        check("wr3_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1; bresp = RESP_OKAY;
        step();
        bvalid = 1'b0;
        check("wr3_single_b", {31'd0, bready}, 32'd0);
        check("wr3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr3_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 4: read SLVERR, response stalled for 4 cycles
        send_cmd(1'b0, 32'h30, 32'h0, 4'h0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = RESP_SLVERR;
        step();
        rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rd4_rsp_valid_stable", {31'd0, rsp_valid}, 32'd1);
            check("rd4_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
            check("rd4_rsp_resp", {30'd0, rsp_resp}, {30'd0, RESP_SLVERR});
            check("rd4_rsp_error", {31'd0, rsp_error}, 32'd1);
            check("rd4_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        check("rd4_cmd_ready_hs_cycle", {31'd0, cmd_ready}, 32'd0);
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rd4_after_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rd4_after_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rd4_payload_hold", {30'd0, rsp_resp}, {30'd0, RESP_SLVERR});
        check("rd4_no_new_aw", {31'd0, awvalid}, 32'd0);

        // 5: reset while in WR with awvalid high
        send_cmd(1'b1, 32'h40, 32'h1111_2222, 4'b1111);
        check("rst5_awvalid_pre", {31'd0, awvalid}, 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("rst5_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        check("rst5_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst5_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        step();
        check("rst5_idle_after", {31'd0, cmd_ready}, 32'd1);
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        check("rd5_arvalid", {31'd0, arvalid}, 32'd1);
        check("rd5_awvalid", {31'd0, awvalid}, 32'd0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = RESP_OKAY;
        step();
        rvalid = 1'b0;
        check("rd5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd5_rsp_rdata", rsp_rdata, 32'h0BADF00D);
        check("rd5_rsp_error", {31'd0, rsp_error}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rd5_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ready_valid_to_axi.md
# ready_valid_to_axi

AXI4-Lite master that turns single-word ready/valid command requests into AXI4-Lite read or write transactions and returns the slave response on a ready/valid response port. Sits between user logic (sequencers, test controllers) and an AXI interconnect, and is the initiator counterpart to the team's AXI-Lite-to-ready/valid slave bridge. Exactly one transaction is outstanding at a time.

## Interface
- C_M00_AXI_DATA_WIDTH, 32, AXI data width and width of the command and response data (32 only).
- C_M00_AXI_ADDR_WIDTH, 32, AXI address width and command address width.
- One clock; reset is asynchronous and active-low.
- M00_AXI_aclk  in  1  clock.
- M00_AXI_aresetn  in  1  asynchronous active-low reset.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR  byte address, passed through unmodified.
- cmd_wdata_i  in  DATA  write data; ignored for reads.
- cmd_wstrb_i  in  DATA/8  byte strobes; present only with RV2AXI_WSTRB_EN.
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
- rsp_write_o  out  1  echo of cmd_write_i.
- rsp_rdata_o  out  DATA  read data; 0 for writes.
- rsp_resp_o  out  2  raw BRESP/RRESP.
- rsp_error_o  out  1  rsp_resp_o[1] (SLVERR or DECERR).
- M00_AXI_aw*/w*/b*/ar*/r*  standard AXI4-Lite master channels; awprot and arprot are fixed at 3'b000.

## Operation
- FSM states: IDLE, WR (AW and W pending), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready_o = 1. On handshake, latch addr, data, strb and the write flag.
  - Write: go to WR and set awvalid and wvalid.
  - Read: go to RD_ADDR and set arvalid.
- WR:
  - awvalid and wvalid each clear independently on their own handshake.
  - Once both have completed, in the same cycle or different cycles, go to WR_RESP.
  - Neither valid is ever withdrawn before its handshake.
- WR_RESP: bready = 1. On B handshake, capture bresp and go to RSP.
- RD_ADDR: arvalid held until handshake, then go to RD_DATA.
- RD_DATA: rready = 1. On R handshake, capture rdata and rresp and go to RSP.
- RSP: rsp_valid_o = 1 with stable payload. On rsp handshake, return to IDLE.
- Response payload registers hold their value outside RSP.
- A new command is never accepted in the cycle of the rsp handshake.

## Timing
- Reset (asynchronous assert, synchronous deassert assumed externally):
  - State goes to IDLE.
  - awvalid, wvalid, arvalid, bready, rready and rsp_valid_o are all 0.
  - rsp payload is 0.
  - cmd_ready_o = 0 while aresetn is low.
- Reset mid-transaction drops every valid immediately. The system owner must reset the slave alongside.
- All AXI valids and readies, and rsp_valid_o, are registered outputs. cmd_ready_o is decoded from state.
- Write latency with a zero-wait slave:
  - cmd accept in cycle 0.
  - AW/W valid in cycle 1.
  - bready in cycle 2.
  - B handshake in cycle 2 at earliest.
  - rsp_valid_o in cycle 3.
- Read latency is the same, with AR/R in place of AW/W/B.
- Back-to-back throughput: rsp handshake in cycle N gives cmd_ready_o in cycle N+1.
- A slave accepting AW several cycles before W, or W before AW, must be handled. No deadlock and no duplicate valid.

## Configuration
- RV2AXI_WSTRB_EN defined:
  - cmd_wstrb_i exists.
  - It is latched with the command and driven on M00_AXI_wstrb.
- Undefined:
  - The port is absent.
  - M00_AXI_wstrb is tied to all ones.

## Structure
- Shared package rv2axi_pkg holds:
  - the state enum;
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
- No sub-module. A single file containing the FSM and the latch registers.

## Test plan
- Write addr 0x4, data 0xDEADBEEF, slave with zero wait and OKAY → AW/W in cycle 1; rsp_valid_o in cycle 3 with write = 1, resp = 00, error = 0.
- Read addr 0x8, slave returns 0x12345678 after 5 wait cycles → arvalid held 5+ cycles; rsp_rdata_o = 0x12345678, error = 0.
- Slave accepts W 3 cycles before AW → wvalid drops after its handshake, awvalid held; exactly one B consumed; resp OKAY.
- Read returning SLVERR, with rsp_ready_i held low for 4 cycles → rsp_valid_o stable 4 cycles; resp = 10, error = 1; cmd_ready_o low until the cycle after the handshake.
- aresetn pulsed low while in WR with awvalid high → all valids 0 immediately; IDLE after release; next read completes normally.
- With RV2AXI_WSTRB_EN, wstrb 4'b0101 → M00_AXI_wstrb = 0101. Without it → 1111.
